// File: rtl/snapshot_page_ctrl.sv
// Snapshot page controller: streams frames into a ring of BRAM pages and
// hands filled pages to the CPU oldest-first, with overflow and error tracking.
module snapshot_page_ctrl #(
    parameter int unsigned C_PAGES   = 4,
    parameter int unsigned C_PAGE_HW = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [15:0] wr_din,
    input  logic        wr_last,
    output logic        bram_clk,
    output logic        bram_rst,
    output logic        bram_en,
    output logic [1:0]  bram_we,
    output logic [11:0] bram_addr,
    output logic [15:0] bram_din,
    input  logic        cpu_ack,
    input  logic        irq_en,
    output logic        irq,
    output logic [2:0]  rd_page,
    output logic [3:0]  fill_cnt,
    output logic [15:0] ovf_cnt,
    output logic [1:0]  err_sticky
);

    localparam int unsigned PW    = $clog2(C_PAGES);
    localparam int unsigned HW_SH = $clog2(C_PAGE_HW);
    localparam logic [3:0]  PAGES = 4'(C_PAGES);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [3:0]    fill;
    logic [15:0]   ovf;
    logic [1:0]    err;
    logic          beat_wr;
    logic          commit;
    logic          drop_done;
    logic          orphan;
    logic          ack_ok;
    logic          ack_err;
    logic [11:0]   wr_base;

    assign bram_clk   = aclk;
    assign bram_rst   = ~aresetn;
    assign rd_page    = 3'(rp);
    assign fill_cnt   = fill;
    assign ovf_cnt    = ovf;
    assign err_sticky = err;

    assign ack_ok  = cpu_ack & (fill != '0);
    assign ack_err = cpu_ack & (fill == '0);
    assign wr_base = 12'(wp) << HW_SH;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A single-beat frame opens and closes in IDLE, so commit/drop can fire there too.
    always_comb begin
        state_nxt = state;
        beat_wr   = 1'b0;
        commit    = 1'b0;
        drop_done = 1'b0;
        orphan    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    if (wr_addr == '0) begin
                        if (fill < PAGES) begin
                            beat_wr = 1'b1;
                            if (wr_last) begin
                                commit = 1'b1;
                            end else begin
                                state_nxt = WRITE;
                            end
                        end else begin
                            if (wr_last) begin
                                drop_done = 1'b1;
                            end else begin
                                state_nxt = DROP;
                            end
                        end
                    end else begin
                        orphan = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (wr_en) begin
                    beat_wr = 1'b1;
                    if (wr_last) begin
                        commit    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (wr_en && wr_last) begin
                    drop_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clr) begin
            state_nxt = IDLE;
            beat_wr   = 1'b0;
            commit    = 1'b0;
            drop_done = 1'b0;
            orphan    = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wp        <= '0;
            rp        <= '0;
            fill      <= '0;
            ovf       <= '0;
            err       <= '0;
            irq       <= 1'b0;
            bram_en   <= 1'b0;
            bram_we   <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            irq     <= irq_en & (fill != '0);
            bram_en <= beat_wr;
            bram_we <= {2{beat_wr}};
            if (beat_wr) begin
                bram_addr <= wr_base + {6'd0, wr_addr};
                bram_din  <= wr_din;
            end
            if (clr) begin
                wp   <= '0;
                rp   <= '0;
                fill <= '0;
                ovf  <= '0;
                err  <= '0;
            end else begin
                if (commit) begin
                    wp <= wp + PW'(1);
                end
                if (ack_ok) begin
                    rp <= rp + PW'(1);
                end
                if (commit && !ack_ok) begin
                    fill <= fill + 4'd1;
                end else if (!commit && ack_ok) begin
                    fill <= fill - 4'd1;
                end
                if (drop_done && (ovf != '1)) begin
                    ovf <= ovf + 16'd1;
                end
                if (orphan) begin
                    err[0] <= 1'b1;
                end
                if (ack_err) begin
                    err[1] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snapshot_page_ctrl.sv
// Randomized bench for snapshot_page_ctrl against a page-queue reference model.
module tb_snapshot_page_ctrl;

    localparam int unsigned P  = 4;
    localparam int unsigned HW = 64;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic        clr     = 1'b0;
    logic        wr_en   = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [15:0] wr_din  = '0;
    logic        wr_last = 1'b0;
    logic        cpu_ack = 1'b0;
    logic        irq_en  = 1'b0;
    logic        bram_clk;
    logic        bram_rst;
    logic        bram_en;
    logic [1:0]  bram_we;
    logic [11:0] bram_addr;
    logic [15:0] bram_din;
    logic        irq;
    logic [2:0]  rd_page;
    logic [3:0]  fill_cnt;
    logic [15:0] ovf_cnt;
    logic [1:0]  err_sticky;

    snapshot_page_ctrl #(.C_PAGES(P), .C_PAGE_HW(HW)) dut (
        .aclk(aclk), .aresetn(aresetn), .clr(clr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_last(wr_last),
        .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_din(bram_din),
        .cpu_ack(cpu_ack), .irq_en(irq_en), .irq(irq), .rd_page(rd_page),
        .fill_cnt(fill_cnt), .ovf_cnt(ovf_cnt), .err_sticky(err_sticky)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of filled page numbers, oldest at the front.
    int m_pages[$];
    int m_wp, m_rp, m_ovf, m_addr, m_din;
    bit [1:0] m_err;
    bit m_in_frame, m_keep, m_irq, m_en;

    task automatic model_reset();
        m_pages.delete();
        m_wp = 0; m_rp = 0; m_ovf = 0; m_addr = 0; m_din = 0;
        m_err = 2'b00; m_in_frame = 0; m_keep = 0; m_irq = 0; m_en = 0;
    endtask

    task automatic model_step();
        int old_fill;
        bit do_commit;
        old_fill  = m_pages.size();
        do_commit = 0;
        m_irq = irq_en && (old_fill != 0);
        m_en  = 0;
        if (clr) begin
            m_pages.delete();
            m_wp = 0; m_rp = 0; m_ovf = 0; m_err = 2'b00; m_in_frame = 0;
            return;
        end
        if (wr_en) begin
            if (!m_in_frame) begin
                if (wr_addr == 0) begin
                    m_in_frame = 1;
                    m_keep = (old_fill < P);
                end else begin
                    m_err[0] = 1'b1;
                end
            end
            if (m_in_frame) begin
                if (m_keep) begin
                    m_en   = 1;
                    m_addr = m_wp * HW + int'(wr_addr);
                    m_din  = int'(wr_din);
                end
                if (wr_last) begin
                    m_in_frame = 0;
                    if (m_keep) do_commit = 1;
                    else if (m_ovf < 65535) m_ovf++;
                end
            end
        end
        if (cpu_ack) begin
            if (old_fill > 0) begin
                void'(m_pages.pop_front());
                m_rp = (m_rp + 1) % P;
            end else begin
                m_err[1] = 1'b1;
            end
        end
        if (do_commit) begin
            m_pages.push_back(m_wp);
            m_wp = (m_wp + 1) % P;
        end
    endtask

    task automatic compare_outputs();
        check("bram_en", bram_en, m_en);
        check("bram_we", bram_we, m_en ? 2'b11 : 2'b00);
        if (m_en) begin
            check("bram_addr", bram_addr, m_addr);
            check("bram_din", bram_din, m_din);
        end
        check("fill_cnt", fill_cnt, m_pages.size());
        check("rd_page", rd_page, m_rp);
        if (m_pages.size() > 0) check("rd_oldest", rd_page, m_pages[0]);
        check("ovf_cnt", ovf_cnt, m_ovf);
        check("err_sticky", err_sticky, m_err);
        check("irq", irq, m_irq);
        check("bram_rst", bram_rst, 1'b0);
    endtask

    task automatic cyc(input bit en, input int a, input bit last, input bit ack, input bit c);
        wr_en   = en;
        wr_addr = 6'(a);
        wr_din  = 16'($urandom);
        wr_last = last;
        cpu_ack = ack;
        clr     = c;
        @(posedge aclk);
        model_step();
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic partial(input int k, input int gap_pct);
        for (int b = 0; b < k; b++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) cyc(0, 0, 0, 0, 0);
            cyc(1, b, 0, 0, 0);
        end
    endtask

    task automatic send_frame(input int len, input int ack_pct, input int gap_pct, input bit ack_last);
        for (int b = 0; b < len; b++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++)
                cyc(0, 0, 0, $urandom_range(99) < ack_pct, 0);
            cyc(1, b, b == len - 1, (b == len - 1) ? ack_last : ($urandom_range(99) < ack_pct), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rst"}, bram_rst, 1'b1);
        check({tag, "_en"}, bram_en, 1'b0);
        check({tag, "_we"}, bram_we, 2'b00);
        check({tag, "_addr"}, bram_addr, 12'h000);
        check({tag, "_din"}, bram_din, 16'h0000);
        check({tag, "_fill"}, fill_cnt, 4'd0);
        check({tag, "_rd"}, rd_page, 3'd0);
        check({tag, "_ovf"}, ovf_cnt, 16'd0);
        check({tag, "_err"}, err_sticky, 2'b00);
        check({tag, "_irq"}, irq, 1'b0);
    endtask

    // Asynchronous reset applied between edges, released on a falling edge.
    task automatic do_reset();
        #2;
        aresetn = 1'b0;
        wr_en = 0; wr_last = 0; cpu_ack = 0; clr = 0; wr_addr = '0;
        #1;
        check_reset_outputs("reset_async");
        model_reset();
        @(posedge aclk);
        #1;
        check_reset_outputs("reset_hold");
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        check_reset_outputs("reset_init");
        @(negedge aclk);
        aresetn = 1'b1;
        idle(2);

        // 40-beat frame, irq follows fill_cnt by a cycle
        irq_en = 1'b1;
        send_frame(40, 0, 0, 0);
        check("d_frame_fill", fill_cnt, 4'd1);
        check("d_frame_irq_lag", irq, 1'b0);
        idle(1);
        check("d_frame_irq", irq, 1'b1);
        cyc(0, 0, 0, 1, 0);
        idle(2);

        // four pages fill, fifth frame dropped
        cyc(0, 0, 0, 0, 1);
        for (int f = 0; f < 5; f++) send_frame(40, 0, 0, 0);
        idle(1);
        check("d_ovf_one", ovf_cnt, 16'd1);
        check("d_fill_full", fill_cnt, 4'd4);

        // commit and ack together with two pages filled
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("d_fill_two", fill_cnt, 4'd2);
        send_frame(12, 0, 0, 1);
        check("d_coinc_fill", fill_cnt, 4'd2);
        check("d_coinc_rp", rd_page, 3'd3);

        // ack on empty and orphan write
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 5, 0, 0, 0);
        idle(1);
        check("d_err_both", err_sticky, 2'b11);
        check("d_err_fill", fill_cnt, 4'd0);
        check("d_orphan_no_wr", bram_en, 1'b0);

        // reset mid-frame, then a clean frame lands on page 0
        partial(20, 0);
        do_reset();
        send_frame(40, 0, 0, 0);
        check("d_after_reset_fill", fill_cnt, 4'd1);

        // clr with three pages filled and irq high
        send_frame(8, 0, 0, 0);
        send_frame(8, 0, 0, 0);
        idle(1);
        check("d_clr_pre_irq", irq, 1'b1);
        cyc(0, 0, 0, 0, 1);
        check("d_clr_fill", fill_cnt, 4'd0);
        check("d_clr_ovf", ovf_cnt, 16'd0);
        idle(1);
        check("d_clr_irq", irq, 1'b0);
        send_frame(10, 0, 0, 0);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(99);
            if ($urandom_range(9) == 0) irq_en = $urandom_range(1);
            if (r < 60) begin
                send_frame($urandom_range(40, 1), 8, 20, $urandom_range(3) == 0);
            end else if (r < 68) begin
                partial($urandom_range(20, 1), 10);
                send_frame($urandom_range(40, 1), 5, 10, 0);
            end else if (r < 80) begin
                for (int k = 0; k < int'($urandom_range(4, 1)); k++) cyc(0, 0, 0, 1, 0);
            end else if (r < 85) begin
                cyc(1, $urandom_range(63, 1), $urandom_range(1), 0, 0);
            end else if (r < 88) begin
                partial($urandom_range(10), 10);
                cyc(0, 0, 0, $urandom_range(1), 1);
            end else if (r < 90) begin
                partial($urandom_range(30, 1), 10);
                do_reset();
            end else if (r < 93) begin
                partial($urandom_range(10, 1), 0);
                cyc(1, $urandom_range(39, 1), 1, 1, 1);
            end else begin
                idle($urandom_range(5, 1));
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
